// File: rtl/contador_multicanal.sv
// Per-channel FIFO word counter with wrap/saturate overflow, sticky overflow flags,
// optional clear-on-read and a valid/ack read port that only accepts requests while idle.
//
// state  | meaning
// S_WAIT | no response pending; accepts req when idle is high
// S_RESP | response held on the outputs until ack
module contador_multicanal #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 5,
    parameter int IDX_W         = 2,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] valid_in,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              ack,
    output logic              valid_contador,
    output logic [CNT_W-1:0]  contador_out,
    output logic              ovf_out,
    output logic              err_idx,
    output logic              busy
);

    typedef enum logic {S_WAIT, S_RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W+1)'(NUM_CH);

    state_t            state;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] clr_sel;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;
    logic              accept;
    logic              idx_ok;

    assign accept = (state == S_WAIT) && req && idle;
    assign idx_ok = ({1'b0, idx} < NUM_CH_W);

    // Out-of-range indices match no channel, so they read as zero and clear nothing.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        clr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_cnt    = cnt[i];
                sel_ovf    = ovf[i];
                clr_sel[i] = (CLEAR_ON_READ != 0) && accept;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_sel[i]) begin
                    // a word arriving on the clearing edge belongs to the new epoch
                    cnt[i] <= valid_in[i] ? CNT_W'(1) : '0;
                    ovf[i] <= 1'b0;
                end else if (valid_in[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_WAIT;
            valid_contador <= 1'b0;
            contador_out   <= '0;
            ovf_out        <= 1'b0;
            err_idx        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (accept) begin
                        state          <= S_RESP;
                        valid_contador <= 1'b1;
                        busy           <= 1'b1;
                        contador_out   <= sel_cnt;
                        ovf_out        <= sel_ovf;
                        err_idx        <= !idx_ok;
                    end
                end
                S_RESP: begin
                    if (ack) begin
                        state          <= S_WAIT;
                        valid_contador <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_contador_multicanal.sv
// Bench for contador_multicanal: four parameter variants share one stimulus stream
// (default, saturating, clear-on-read, three channels).
module tb_contador_multicanal;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] valid_in = '0;
    logic       idle = 1'b0;
    logic       req = 1'b0;
    logic [1:0] idx = '0;
    logic       ack = 1'b0;

    logic       v0, v1, v2, v3;
    logic [4:0] c0, c1, c2, c3;
    logic       o0, o1, o2, o3;
    logic       e0, e1, e2, e3;
    logic       b0, b1, b2, b3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    contador_multicanal u_def (
        .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
        .ack(ack), .valid_contador(v0), .contador_out(c0), .ovf_out(o0), .err_idx(e0), .busy(b0)
    );

    contador_multicanal #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
        .ack(ack), .valid_contador(v1), .contador_out(c1), .ovf_out(o1), .err_idx(e1), .busy(b1)
    );

    contador_multicanal #(.CLEAR_ON_READ(1)) u_cor (
        .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
        .ack(ack), .valid_contador(v2), .contador_out(c2), .ovf_out(o2), .err_idx(e2), .busy(b2)
    );

    contador_multicanal #(.NUM_CH(3)) u_three (
        .clk(clk), .reset(reset), .valid_in(valid_in[2:0]), .idle(idle), .req(req), .idx(idx),
        .ack(ack), .valid_contador(v3), .contador_out(c3), .ovf_out(o3), .err_idx(e3), .busy(b3)
    );

    typedef struct {
        logic [3:0] vin;
        logic       idle;
        logic       req;
        logic [1:0] idx;
        logic       ack;
        logic       v;
        logic [4:0] c;
        logic       o;
        logic       e;
        logic       b;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid_in = '0; req = 1'b0; ack = 1'b0; idle = 1'b1; idx = '0;
        step();
        reset = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] v, input int n);
        valid_in = v;
        repeat (n) step();
        valid_in = '0;
    endtask

    task automatic read_start(input logic [1:0] i);
        idle = 1'b1; req = 1'b1; idx = i;
        step();
        req = 1'b0;
    endtask

    task automatic read_end();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        // vin idle req idx ack | valid cnt ovf err busy   (default instance)
        vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0});
        vq.push_back('{4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});

        @(negedge clk);
        do_reset();
        check("reset_valid", {31'd0, v0}, 32'd0);
        check("reset_busy", {31'd0, b0}, 32'd0);
        check("reset_cnt", {27'd0, c0}, 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            valid_in = vq[i].vin; idle = vq[i].idle; req = vq[i].req;
            idx = vq[i].idx; ack = vq[i].ack;
            step();
            check($sformatf("vec%0d", i), {23'd0, v0, c0, o0, e0, b0},
                  {23'd0, vq[i].v, vq[i].c, vq[i].o, vq[i].e, vq[i].b});
        end
        valid_in = '0; req = 1'b0; ack = 1'b0;

        // counter max boundary, then wrap vs saturate; clear-on-read variant restarts per read
        do_reset();
        pulse(4'b0001, 31);
        read_start(2'd0);
        check("max_def", {26'd0, v0, c0}, {26'd0, 1'b1, 5'd31});
        check("max_def_ovf", {31'd0, o0}, 32'd0);
        check("max_sat", {26'd0, c1, o1}, {26'd0, 5'd31, 1'b0});
        check("max_cor", {26'd0, c2, o2}, {26'd0, 5'd31, 1'b0});
        read_end();
        check("ack_drop", {30'd0, v0, b0}, 32'd0);
        check("ack_hold_cnt", {27'd0, c0}, 32'd31);
        pulse(4'b0001, 2);
        read_start(2'd0);
        check("wrap_def", {26'd0, c0, o0}, {26'd0, 5'd1, 1'b1});
        check("sat_hold", {26'd0, c1, o1}, {26'd0, 5'd31, 1'b1});
        check("cor_epoch", {26'd0, c2, o2}, {26'd0, 5'd2, 1'b0});
        check("wrap_three", {26'd0, c3, o3}, {26'd0, 5'd1, 1'b1});
        read_end();

        // idle gating: request held with idle low produces nothing
        req = 1'b1; idle = 1'b0; idx = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle_gate%0d", i), {31'd0, v0}, 32'd0);
        end
        idle = 1'b1;
        step();
        req = 1'b0;
        check("idle_accept", {25'd0, v0, c0, o0}, {25'd0, 1'b1, 5'd1, 1'b1});
        read_end();

        // clear-on-read racing a word on the same channel
        do_reset();
        pulse(4'b0010, 4);
        valid_in = 4'b0010;
        read_start(2'd1);
        valid_in = '0;
        check("race_resp", {25'd0, v2, c2, o2}, {25'd0, 1'b1, 5'd4, 1'b0});
        read_end();
        read_start(2'd1);
        check("race_second", {26'd0, c2, o2}, {26'd0, 5'd1, 1'b0});
        check("nondestr_def", {27'd0, c0}, 32'd5);
        read_end();
        pulse(4'b0010, 33);
        valid_in = 4'b0010;
        read_start(2'd1);
        valid_in = '0;
        check("cor_ovf_seen", {26'd0, c2, o2}, {26'd0, 5'd1, 1'b1});
        read_end();
        read_start(2'd1);
        check("cor_ovf_clr", {26'd0, c2, o2}, {26'd0, 5'd1, 1'b0});
        read_end();

        // invalid index on the three-channel variant
        do_reset();
        pulse(4'b0001, 2);
        read_start(2'd3);
        check("inv_resp", {24'd0, v3, c3, o3, e3, b3}, {24'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1});
        check("inv_def_ok", {31'd0, e0}, 32'd0);
        read_end();
        check("inv_err_hold", {31'd0, e3}, 32'd1);
        read_start(2'd0);
        check("inv_then_ok", {26'd0, c3, e3}, {26'd0, 5'd2, 1'b0});
        read_end();

        // asynchronous reset while a response is pending
        pulse(4'b0100, 3);
        read_start(2'd2);
        check("pre_reset", {26'd0, v0, c0}, {26'd0, 1'b1, 5'd3});
        #2 reset = 1'b0;
        #1;
        check("areset_now", {25'd0, v0, b0, c0}, 32'd0);
        check("areset_sat", {30'd0, v1, b1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        read_start(2'd2);
        check("post_reset", {25'd0, v0, c0, o0}, {25'd0, 1'b1, 5'd0, 1'b0});
        read_end();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
